// File: rtl/oc_ram_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
// Pending-read record carries the owner and the out-of-range flag.
package oc_ram_arb_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 3840;

  typedef logic mst_idx_t;

  typedef struct packed {
    logic     valid;
    mst_idx_t owner;
    logic     oor;
  } pend_rd_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer
// register flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr <= 1'b0;
    else if (|gnt)   ptr <= gnt[0];
  end
endmodule

// File: rtl/oc_ram_arbiter2.sv
// Shares one single-port RAM between two Avalon-MM masters: round-robin
// grant, range check, read-response routing, quiesce drain and proto error.
module oc_ram_arbiter2
  import oc_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata,
  input  logic                quiesce,
  output logic                quiesced,
  output logic                err_proto
);
  localparam int BE_W = DATA_W / 8;

  logic [1:0]                 rd, wr, req, gnt, in_rng;
  logic [1:0][ADDR_W-1:0]     addr;
  logic [1:0][BE_W-1:0]       be;
  logic [1:0][DATA_W-1:0]     wdata;
  mst_idx_t                   gsel;
  pend_rd_t                   pend;
  logic                       rst_q, hold, err_q, quiesced_q;
  logic [DATA_W-1:0]          rdata;

  assign rd    = {m1_read, m0_read};
  assign wr    = {m1_write, m0_write};
  assign req   = rd | wr;
  assign addr  = {m1_address, m0_address};
  assign be    = {m1_byteenable, m0_byteenable};
  assign wdata = {m1_writedata, m0_writedata};

  for (genvar k = 0; k < 2; k++) begin : g_rng
    assign in_rng[k] = {1'b0, addr[k]} < (ADDR_W+1)'(DEPTH);
  end

  // rst_q keeps grants blocked for the first cycle after reset falls.
  always_ff @(posedge clk) rst_q <= reset;
  assign hold = reset | rst_q | quiesce;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .hold  (hold),
    .gnt   (gnt)
  );

  assign gsel = gnt[1];

  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    if (|gnt) begin
      ram_address    = addr[gsel];
      ram_byteenable = be[gsel];
      ram_writedata  = wdata[gsel];
    end
  end

  assign ram_chipselect = |(gnt & in_rng);
  assign ram_write      = |(gnt & wr & in_rng);
  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  // read+write together counts as a write, so it never opens a read slot
  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      err_q      <= 1'b0;
      quiesced_q <= 1'b0;
    end else begin
      pend.valid <= |(gnt & rd & ~wr);
      pend.owner <= gsel;
      pend.oor   <= ~in_rng[gsel];
      if (|(rd & wr)) err_q <= 1'b1;
      quiesced_q <= quiesce & ~pend.valid;
    end
  end

  assign rdata            = pend.oor ? '0 : ram_readdata;
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = pend.valid & (pend.owner == 1'b0) & ~reset;
  assign m1_readdatavalid = pend.valid & (pend.owner == 1'b1) & ~reset;
  assign quiesced         = quiesced_q & ~reset;
  assign err_proto        = err_q & ~reset;
endmodule

// File: tb/tb_oc_ram_arbiter2.sv
// Directed bench for oc_ram_arbiter2 with a behavioural 1-cycle-latency RAM.
module tb_oc_ram_arbiter2;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write;
  logic [31:0] ram_writedata, ram_readdata;
  logic        quiesce, quiesced, err_proto;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oc_ram_arbiter2 dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .quiesce(quiesce), .quiesced(quiesced), .err_proto(err_proto)
  );

  // RAM model: byte-enabled write, registered read data
  logic [31:0] mem [0:3839];
  logic [31:0] rdq = '0;
  always @(posedge clk) begin
    if (ram_chipselect && ram_address < 12'd3840) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        rdq <= mem[ram_address];
      end
    end
  end
  assign ram_readdata = rdq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drv0(input logic r, input logic w, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    m0_read = r; m0_write = w; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    m1_read = r; m1_write = w; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  int c0, c1;

  initial begin
    reset = 1; quiesce = 0;
    drv0(1, 0, 12'h010, 0, 4'hF);
    drv1(0, 0, 12'h000, 0, 4'hF);
    repeat (3) tick();
    mid();
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_quiesced", quiesced, 0);
    chk("rst_err", err_proto, 0);
    tick(); reset = 0;
    mid();
    chk("post_rst_wait0", m0_waitrequest, 1);
    chk("post_rst_cs", ram_chipselect, 0);
    chk("post_rst_wr", ram_write, 0);

    // m0 write then read back
    tick(); drv0(0, 1, 12'h010, 32'hA5A5_0001, 4'hF);
    mid();
    chk("t1_wr_wait", m0_waitrequest, 0);
    chk("t1_wr_ramwr", ram_write, 1);
    tick(); drv0(1, 0, 12'h010, 0, 4'hF);
    mid();
    chk("t1_rd_wait", m0_waitrequest, 0);
    chk("t1_rd_rdv_early", m0_readdatavalid, 0);
    tick(); idle();
    mid();
    chk("t1_rdv0", m0_readdatavalid, 1);
    chk("t1_data", m0_readdata, 32'hA5A5_0001);
    chk("t1_rdv1", m1_readdatavalid, 0);
    tick();
    mid();
    chk("t1_rdv0_once", m0_readdatavalid, 0);

    // m1 byte-lane merge, plus seed word 0
    tick(); drv1(0, 1, 12'h000, 32'h0BAD_F00D, 4'hF);
    tick(); drv1(0, 1, 12'h020, 32'h1234_5678, 4'hF);
    mid();
    chk("t3_wr_wait", m1_waitrequest, 0);
    tick(); drv1(0, 1, 12'h020, 32'hFFFF_FFFF, 4'h2);
    tick(); drv1(1, 0, 12'h020, 0, 4'hF);
    mid();
    chk("t3_rd_wait", m1_waitrequest, 0);
    tick(); idle();
    mid();
    chk("t3_rdv1", m1_readdatavalid, 1);
    chk("t3_data", m1_readdata, 32'h1234_FF78);
    chk("t3_rdv0", m0_readdatavalid, 0);

    // contention: strict alternation starting with m0
    c0 = 0; c1 = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 6) begin
        drv0(1, 0, 12'h010, 0, 4'hF);
        drv1(1, 0, 12'h020, 0, 4'hF);
      end else idle();
      mid();
      if (k < 6) begin
        chk($sformatf("t2_wait0_%0d", k), m0_waitrequest, (k % 2 == 1));
        chk($sformatf("t2_wait1_%0d", k), m1_waitrequest, (k % 2 == 0));
      end
      if (k > 0) begin
        chk($sformatf("t2_rdv0_%0d", k), m0_readdatavalid, ((k-1) % 2 == 0));
        chk($sformatf("t2_rdv1_%0d", k), m1_readdatavalid, ((k-1) % 2 == 1));
        if ((k-1) % 2 == 0) chk($sformatf("t2_d0_%0d", k), m0_readdata, 32'hA5A5_0001);
        else                chk($sformatf("t2_d1_%0d", k), m1_readdata, 32'h1234_FF78);
      end
      c0 += int'(m0_readdatavalid);
      c1 += int'(m1_readdatavalid);
    end
    chk("t2_cnt0", c0, 3);
    chk("t2_cnt1", c1, 3);

    // out-of-range write/read at DEPTH, then last in-range word
    tick(); drv0(0, 1, 12'hF00, 32'hDEAD_BEEF, 4'hF);
    mid();
    chk("t4_wr_wait", m0_waitrequest, 0);
    chk("t4_wr_cs", ram_chipselect, 0);
    tick(); drv0(1, 0, 12'hF00, 0, 4'hF);
    mid();
    chk("t4_rd_cs", ram_chipselect, 0);
    tick(); drv0(1, 0, 12'h000, 0, 4'hF);
    mid();
    chk("t4_oor_rdv", m0_readdatavalid, 1);
    chk("t4_oor_data", m0_readdata, 32'h0);
    chk("t4_w0_cs", ram_chipselect, 1);
    tick(); drv0(1, 0, 12'hEFF, 0, 4'hF);
    mid();
    chk("t4_w0_rdv", m0_readdatavalid, 1);
    chk("t4_w0_data", m0_readdata, 32'h0BAD_F00D);
    chk("t4_last_cs", ram_chipselect, 1);
    tick(); idle();
    tick();

    // quiesce with a read in flight; m0 owns the pointer slot after m0-only traffic
    tick(); drv0(1, 0, 12'h010, 0, 4'hF);
    mid();
    chk("t5_rd_wait", m0_waitrequest, 0);
    tick(); idle(); drv1(1, 0, 12'h020, 0, 4'hF); quiesce = 1;
    mid();
    chk("t5_q_wait1_a", m1_waitrequest, 1);
    chk("t5_q_cs", ram_chipselect, 0);
    chk("t5_q_rdv0", m0_readdatavalid, 1);
    chk("t5_q_data", m0_readdata, 32'hA5A5_0001);
    chk("t5_quiesced_a", quiesced, 0);
    tick();
    mid();
    chk("t5_q_wait1_b", m1_waitrequest, 1);
    chk("t5_quiesced_b", quiesced, 0);
    tick();
    mid();
    chk("t5_q_wait1_c", m1_waitrequest, 1);
    chk("t5_quiesced_c", quiesced, 1);
    tick(); quiesce = 0;
    mid();
    chk("t5_release_wait1", m1_waitrequest, 0);
    chk("t5_quiesced_d", quiesced, 1);
    tick(); idle();
    mid();
    chk("t5_rdv1", m1_readdatavalid, 1);
    chk("t5_data1", m1_readdata, 32'h1234_FF78);
    chk("t5_quiesced_e", quiesced, 0);

    // read and write together
    tick(); drv0(1, 1, 12'h030, 32'h0000_0077, 4'hF);
    mid();
    chk("t6_wait", m0_waitrequest, 0);
    chk("t6_ramwr", ram_write, 1);
    chk("t6_err_pre", err_proto, 0);
    tick(); idle();
    mid();
    chk("t6_rdv", m0_readdatavalid, 0);
    chk("t6_err", err_proto, 1);
    repeat (3) tick();
    mid();
    chk("t6_err_hold", err_proto, 1);

    // reset the cycle after a read is accepted
    tick(); drv0(1, 0, 12'h010, 0, 4'hF);
    mid();
    chk("t7_wait", m0_waitrequest, 0);
    tick(); idle(); reset = 1;
    mid();
    chk("t7_rdv_in_rst", m0_readdatavalid, 0);
    tick(); reset = 0;
    mid();
    chk("t7_rdv_after", m0_readdatavalid, 0);
    chk("t7_err_clr", err_proto, 0);
    tick();
    mid();
    chk("t7_rdv_late", m0_readdatavalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/oc_ram_arbiter2.md
Name: oc_ram_arbiter2

Overview:
- Shares one single-port on-chip RAM (3840 x 32, byte-enabled, 1-cycle read latency, unregistered output) between two Avalon-MM masters, e.g. CPU data port and a DMA/accelerator port.
- Round-robin arbitration, at most one access per cycle.
- Generates waitrequest and readdatavalid per master and blocks out-of-range accesses.
- Provides a quiesce handshake so software or the reset controller can drain traffic before freezing the RAM.

Parameters:
- ADDR_W, 12: word-address width of masters and RAM.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- DEPTH, 3840: number of valid words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  DATA_W/8  master 0 byte lanes.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall; request accepted when request & !waitrequest.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_* : identical set for master 1.
- ram_address  out  ADDR_W  to RAM.
- ram_byteenable  out  DATA_W/8  to RAM.
- ram_chipselect  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  DATA_W  to RAM.
- ram_readdata  in  DATA_W  from RAM; valid the cycle after the address is issued.
- quiesce  in  1  stop granting new accesses.
- quiesced  out  1  quiesce held and no read in flight.
- err_proto  out  1  sticky: a master asserted read and write together.

Behaviour:
- Reset: all outputs are driven to these values while reset is high and in the first cycle after it falls:
  - m0_waitrequest=1, m1_waitrequest=1.
  - readdatavalid=0 on both masters.
  - ram_chipselect=0, ram_write=0.
  - quiesced=0, err_proto=0.
  - Priority pointer = master 0; in-flight read state cleared.
- Reset mid-read: any in-flight read is dropped and no readdatavalid is produced for it.
- Request: master k requests when mk_read | mk_write.
- Grant: combinational in the same cycle.
  - Only one master requests -> that master is granted.
  - Both request -> the master indicated by the pointer is granted.
  - No grant while quiesce=1 or reset=1.
- waitrequest:
  - Granted master: 0.
  - Non-granted or non-requesting master: 1.
  - Zero-wait accept is possible; back-to-back grants to a sole requester occur every cycle.
- Pointer update: on each grant, the pointer moves to the other master. Strict alternation under contention.
- RAM drive: ram_address, ram_byteenable and ram_writedata are muxed from the granted master, 0 when no grant.
  - ram_chipselect = grant & in-range.
  - ram_write = grant & write & in-range.
- Write: completes at accept; no response.
  - Out-of-range write (address >= DEPTH) is accepted and silently dropped (chipselect=0).
- Read: accepted in cycle N.
  - Registered pending flag = owner index plus oor bit.
  - Cycle N+1: owner's readdatavalid=1.
  - Readdata = ram_readdata if in range, else 0.
  - The non-owner's readdatavalid=0. Both readdata buses may carry ram_readdata; they are only meaningful with valid.
  - Reads pipeline: a read in N and a read or write in N+1 are both legal.
- read & write asserted together by one master:
  - Treated as a write; no read response.
  - err_proto set, cleared only by reset.
- quiesce:
  - Takes effect in the same cycle: both waitrequests go to 1 and no new access is issued.
  - quiesced = quiesce & no read pending, registered. It rises at the earliest 1 cycle after quiesce with no pending read, and falls the cycle after quiesce drops.
- Widths: address compare is unsigned ADDR_W. No arithmetic wraps; addresses DEPTH..2^ADDR_W-1 are out-of-range, not aliased.

Decomposition:
- Package oc_ram_arb_pkg holds:
  - ADDR_W, DATA_W and DEPTH defaults.
  - Master-index typedef (1 bit).
  - Pending-read struct {valid, owner, oor}.
- Sub-module rr_arb2 contains the two-requester round-robin grant logic plus pointer register, with inputs req[1:0] and hold, and output one-hot gnt[1:0].
- Datapath muxing, read tracking and the quiesce/err logic stay in the top.

Test Plan:
- Reset, then m0 writes 0xA5A5_0001 to addr 0x010 with byteenable 0xF, then reads 0x010. Required: m0_waitrequest=0 on both accesses; m0_readdatavalid=1 exactly one cycle after the read is accepted, with data 0xA5A5_0001; m1_readdatavalid stays 0.
- m0 and m1 both issue continuous reads for 6 cycles. Required: grants alternate m0,m1,m0,m1,m0,m1; each master gets exactly 3 readdatavalid pulses, each one cycle after the matching accept.
- m1 writes 0x1234_5678, then writes 0xFFFF_FFFF to the same word with byteenable 0x2, then reads it back. Required: returns 0x1234_FF78.
- m0 writes 0xDEAD_BEEF to addr 0xF00 (= 3840, out of range), then reads 0xF00. Required: ram_chipselect=0 for both accesses; readdatavalid=1 with readdata 0; a subsequent in-range read of word 0 returns its prior contents.
- Issue a read from m0, and in the next cycle raise quiesce with m1 requesting. Required: m1_waitrequest=1 while quiesce is high; m0 read data is still delivered; quiesced=1 one cycle after the pending read clears; the m1 grant follows the cycle quiesce drops.
- m0 asserts read and write together. Required: treated as a write; no readdatavalid; err_proto=1 and held until reset.
- Separately, a read accepted and reset asserted the next cycle. Required: no readdatavalid.
